present_nibble_ctrl: RTL

- Host-side controller that sequences the serial PRESENT core over the 8-pin nibble bus: 2-bit address, 4-bit data in, 8-bit data out.
- Assembles the 64-bit plaintext and 80-bit key byte by byte, launches the core and waits for completion.
- Latches the 64-bit ciphertext and streams it back one byte per read command.
- Sits between the top-level pin mapping and core_serial; replaces the constant PlainText/Key/Start tie-offs.

---
 rtl/present_nibble_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/present_nibble_ctrl.sv
// present_nibble_ctrl
//   Host-side sequencer for the serial PRESENT core over the 8-pin nibble bus.
//   It builds the plaintext and key a byte at a time from two nibble writes,
//   launches the core with a one-cycle start pulse and waits for completion.
//   It then latches the ciphertext and hands it back one byte per READ_NEXT.
//
// Ports
//   Clk_ik        in   1   system clock, one bus transaction per rising edge
//   Reset_ir      in   1   asynchronous reset, active-high
//   Addr_ib       in   2   00 none, 01 command, 10 InputData[3:0], 11 InputData[7:4]
//   Data_ib       in   4   bus write nibble (command code when Addr=01)
//   Data_ob       out  8   status for Addr 0x, OutputData for Addr 1x
//   PlainText_ob  out  64  plaintext to core
//   Key_ob        out  80  key to core
//   Start_o       out  1   one-cycle start pulse to core
//   CipherText_ib in   64  core result
//   Ready_i       in   1   core idle / result valid
//
// Optional feature (macro PRESENT_CTRL_TIMEOUT_EN)
//   A run watchdog aborts ARM/RUN after TIMEOUT_CYCLES cycles, setting the
//   sticky timeout and error flags. Without the macro the controller waits
//   indefinitely and status bit 6 always reads 0.

module present_nibble_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk_ik,
  input  logic        Reset_ir,
  input  logic [1:0]  Addr_ib,
  input  logic [3:0]  Data_ib,
  output logic [7:0]  Data_ob,
  output logic [63:0] PlainText_ob,
  output logic [79:0] Key_ob,
  output logic        Start_o,
  input  logic [63:0] CipherText_ib,
  input  logic        Ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

  localparam logic [1:0] ADDR_CMD = 2'b01;
  localparam logic [1:0] ADDR_LO  = 2'b10;
  localparam logic [1:0] ADDR_HI  = 2'b11;

  localparam logic [3:0] CMD_LOAD_PT  = 4'h1;
  localparam logic [3:0] CMD_LOAD_KEY = 4'h2;
  localparam logic [3:0] CMD_START    = 4'h3;
  localparam logic [3:0] CMD_READ     = 4'h4;
  localparam logic [3:0] CMD_CLEAR    = 4'h5;

  state_e      state_q;
  logic [7:0]  in_q;
  logic [7:0]  out_q;
  logic [63:0] pt_q;
  logic [79:0] key_q;
  logic [63:0] ct_q;
  logic [3:0]  pt_cnt_q;
  logic [3:0]  key_cnt_q;
  logic        err_q;
  logic        to_q;
  logic        start_q;

  logic        cmd_d;
  logic        clear_d;
  logic        pt_full_d;
  logic        key_full_d;
  logic        busy_d;
  logic        expire_d;
  logic [63:0] ct_rot_d;
  logic [7:0]  status_d;

  assign cmd_d      = (Addr_ib == ADDR_CMD);
  assign clear_d    = cmd_d && (Data_ib == CMD_CLEAR);
  assign pt_full_d  = (pt_cnt_q == 4'd8);
  assign key_full_d = (key_cnt_q == 4'd10);
  assign busy_d     = (state_q == S_ARM) || (state_q == S_RUN);
  // Rotating rather than shifting keeps all 8 bytes, so reads wrap cleanly.
  assign ct_rot_d   = {ct_q[55:0], ct_q[63:56]};

`ifdef PRESENT_CTRL_TIMEOUT_EN
  localparam int CW_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_MIN < 8) ? 8 : CW_MIN;

  logic [CW-1:0] tcnt_q;

  // Held at zero outside a run, so the first ARM cycle always sees 0.
  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir)     tcnt_q <= '0;
    else if (!busy_d) tcnt_q <= '0;
    else              tcnt_q <= tcnt_q + CW'(1);
  end

  // Fires on the TIMEOUT_CYCLES-th cycle spent in ARM/RUN.
  assign expire_d = busy_d && (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expire_d       = 1'b0;
`endif

  always_comb begin
    status_d    = 8'h00;
    status_d[0] = (state_q == S_IDLE) || (state_q == S_DONE);
    status_d[1] = busy_d;
    status_d[2] = (state_q == S_DONE);
    status_d[3] = err_q;
    status_d[4] = pt_full_d;
    status_d[5] = key_full_d;
    status_d[6] = to_q;
  end

  assign Data_ob      = Addr_ib[1] ? out_q : status_d;
  assign PlainText_ob = pt_q;
  assign Key_ob       = key_q;
  assign Start_o      = start_q;

  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      state_q   <= S_IDLE;
      in_q      <= '0;
      out_q     <= '0;
      pt_q      <= '0;
      key_q     <= '0;
      ct_q      <= '0;
      pt_cnt_q  <= '0;
      key_cnt_q <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;

      if (Addr_ib == ADDR_LO) in_q[3:0] <= Data_ib;
      if (Addr_ib == ADDR_HI) in_q[7:4] <= Data_ib;

      // CLEAR outranks every FSM event, including a completing run.
      if (clear_d) begin
        state_q   <= S_IDLE;
        pt_cnt_q  <= '0;
        key_cnt_q <= '0;
        err_q     <= 1'b0;
        to_q      <= 1'b0;
        ct_q      <= '0;
        out_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (cmd_d) begin
              case (Data_ib)
                CMD_LOAD_PT: begin
                  pt_q <= {pt_q[55:0], in_q};
                  if (!pt_full_d) pt_cnt_q <= pt_cnt_q + 4'd1;
                end
                CMD_LOAD_KEY: begin
                  key_q <= {key_q[71:0], in_q};
                  if (!key_full_d) key_cnt_q <= key_cnt_q + 4'd1;
                end
                CMD_START: begin
                  if (pt_full_d && key_full_d) begin
                    state_q <= S_ARM;
                    start_q <= 1'b1;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                CMD_READ: begin
                  if (state_q == S_DONE) begin
                    ct_q  <= ct_rot_d;
                    out_q <= ct_rot_d[63:56];
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                default: err_q <= 1'b1;
              endcase
            end
          end
          S_ARM, S_RUN: begin
            // Operands stay frozen during a run; any command but CLEAR is refused.
            if (cmd_d) err_q <= 1'b1;
            if (expire_d) begin
              to_q    <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (state_q == S_ARM) begin
              // Ready dropping is the core's acknowledge of the start pulse.
              if (!Ready_i) state_q <= S_RUN;
            end else if (Ready_i) begin
              state_q <= S_DONE;
              ct_q    <= CipherText_ib;
              out_q   <= CipherText_ib[63:56];
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
